// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (core vs. debug system-bus master).
// Round-robin grant in IDLE, registered transaction in BUSY, one-cycle done in RESP.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_req,
    input  logic                    c_we,
    input  logic [ADDR_WIDTH-1:0]   c_addr,
    input  logic [DATA_WIDTH-1:0]   c_wdata,
    input  logic [DATA_WIDTH/8-1:0] c_be,
    output logic                    c_done,
    output logic                    c_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_done,
    output logic                    d_err,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } req_t;

    state_t        state, state_nxt;
    req_t          cap, c_in, d_in;
    logic          owner, last_owner;   // 0 = core, 1 = debug
    logic          grant, win;
    logic [CW-1:0] wd_cnt;
    logic [CW:0]   wd_inc;
    logic          timeout_hit;
    logic          err_r;

    assign c_in = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be};
    assign d_in = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};

    // Abort fires on the BUSY cycle that would bring the unacked count up to TIMEOUT.
    assign wd_inc      = {1'b0, wd_cnt} + (CW+1)'(1);
    assign timeout_hit = (TIMEOUT != 0) && (wd_inc == (CW+1)'(TIMEOUT));

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        if (c_req && d_req) win = ~last_owner;
        else                win = d_req;
        case (state)
            IDLE: if (c_req || d_req) begin
                grant     = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (mem_ack || timeout_hit) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            wd_cnt     <= '0;
            err_r      <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                cap        <= win ? d_in : c_in;
                owner      <= win;
                last_owner <= win;
            end
            if (state == BUSY && !mem_ack) wd_cnt <= wd_cnt + CW'(1);
            else if (state == RESP)        wd_cnt <= '0;
            // An ack in the timeout cycle takes priority and completes normally.
            if (state == BUSY) begin
                if (mem_ack) begin
                    rdata <= cap.we ? '0 : mem_rdata;
                    err_r <= 1'b0;
                end else if (timeout_hit) begin
                    rdata <= '0;
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = cap.we;
    assign mem_addr  = cap.addr;
    assign mem_wdata = cap.wdata;
    assign mem_be    = cap.be;
    assign c_done    = (state == RESP) && !owner;
    assign d_done    = (state == RESP) &&  owner;
    assign c_err     = c_done && err_r;
    assign d_err     = d_done && err_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs and checks both happen at the falling edge.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  c_be = 0, d_be = 0;
    logic        c_done, c_err, d_done, d_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 0;
    logic [31:0] mem_rdata = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_done(c_done), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_err(d_err),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c_req = 1'b1;
        c_addr = 32'h44;
        tick();
        tick();
        tests++;
        if ({c_done, c_err, d_done, d_err, mem_req, mem_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000000", {c_done, c_err, d_done, d_err, mem_req, mem_we});
        end
        tests++;
        if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'b0) begin
            fails++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h want all 0", rdata, mem_addr, mem_wdata, mem_be);
        end
        c_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_core_read();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100;
        tick();
        tests++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            fails++;
            $display("FAIL core_read_issue: req=%b we=%b addr=%h want 1 0 00000100", mem_req, mem_we, mem_addr);
        end
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tests++;
        if (c_done !== 1'b0) begin
            fails++;
            $display("FAIL core_read_early_done: got %b want 0", c_done);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tests++;
        if ({c_done, c_err, d_done, mem_req, rdata} !== {4'b1000, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL core_read_done: done=%b err=%b d_done=%b req=%b rdata=%h want 1 0 0 0 deadbeef",
                     c_done, c_err, d_done, mem_req, rdata);
        end
        c_req = 1'b0;
        tick();
        tests++;
        if ({c_done, mem_req, rdata} !== {2'b00, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL core_read_hold: done=%b req=%b rdata=%h want 0 0 deadbeef", c_done, mem_req, rdata);
        end
    endtask

    task automatic test_arb_both();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_req = 1'b1; c_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h300;
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
            fails++;
            $display("FAIL arb_first_grant: req=%b addr=%h want 1 00000300", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h11;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({d_done, c_done, rdata} !== {2'b10, 32'h11}) begin
            fails++;
            $display("FAIL arb_d_done: d=%b c=%b rdata=%h want 1 0 00000011", d_done, c_done, rdata);
        end
        d_req = 1'b0;
        tick();
        tests++;
        if ({mem_req, c_done, d_done} !== 3'b000) begin
            fails++;
            $display("FAIL arb_gap: req=%b c=%b d=%b want 000", mem_req, c_done, d_done);
        end
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
            fails++;
            $display("FAIL arb_second_grant: req=%b addr=%h want 1 00000200", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({c_done, d_done} !== 2'b10) begin
            fails++;
            $display("FAIL arb_c_done: c=%b d=%b want 10", c_done, d_done);
        end
        c_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_dbg;
        exp_dbg = 4'b0101;   // bit i set: transaction i belongs to debug (D,C,D,C)
        c_req = 1'b1; c_addr = 32'hC00;
        d_req = 1'b1; d_addr = 32'hD00;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({mem_req, mem_addr} !== {1'b1, exp_dbg[i] ? 32'hD00 : 32'hC00}) begin
                fails++;
                $display("FAIL b2b_grant%0d: req=%b addr=%h want dbg=%b", i, mem_req, mem_addr, exp_dbg[i]);
            end
            mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(i);
            tick();
            mem_ack = 1'b0;
            tests++;
            if ({d_done, c_done, rdata} !== {exp_dbg[i], ~exp_dbg[i], 32'hA0 + 32'(i)}) begin
                fails++;
                $display("FAIL b2b_done%0d: d=%b c=%b rdata=%h want dbg=%b rdata=%h",
                         i, d_done, c_done, rdata, exp_dbg[i], 32'hA0 + 32'(i));
            end
            tick();
        end
        c_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_debug_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h12345678; d_be = 4'b0011;
        tick();
        d_addr = 32'hFFF0; d_wdata = 32'h0; d_be = 4'hF; d_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {2'b11, 32'h400, 32'h12345678, 4'b0011}) begin
                fails++;
                $display("FAIL dwr_captured%0d: req=%b we=%b addr=%h wdata=%h be=%b", i, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
            end
            if (i == 0) tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({d_done, d_err, c_done, rdata} !== {3'b100, 32'h0}) begin
            fails++;
            $display("FAIL dwr_done: d=%b err=%b c=%b rdata=%h want 1 0 0 00000000", d_done, d_err, c_done, rdata);
        end
        d_req = 1'b0;
        tick();
        // stray ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'h99;
        tick();
        mem_ack = 1'b0;
        tick();
        tests++;
        if ({c_done, d_done, mem_req, rdata} !== {3'b000, 32'h0}) begin
            fails++;
            $display("FAIL idle_ack_ignored: c=%b d=%b req=%b rdata=%h want 0 0 0 0", c_done, d_done, mem_req, rdata);
        end
    endtask

    task automatic test_timeout();
        int hi;
        // ack on the last allowed cycle is a normal completion
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h500;
        tick(); tick(); tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({c_done, c_err, rdata} !== {2'b10, 32'h77}) begin
            fails++;
            $display("FAIL to_ack_race: done=%b err=%b rdata=%h want 1 0 00000077", c_done, c_err, rdata);
        end
        tick();
        // no ack at all: abort after 4 mem_req cycles
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req === 1'b1) hi++;
            else break;
        end
        tests++;
        if (hi !== 4) begin
            fails++;
            $display("FAIL to_req_cycles: got %0d want 4", hi);
        end
        tests++;
        if ({c_done, c_err, d_done, rdata} !== {3'b110, 32'h0}) begin
            fails++;
            $display("FAIL to_abort: done=%b err=%b d=%b rdata=%h want 1 1 0 0", c_done, c_err, d_done, rdata);
        end
        c_req = 1'b0;
        tick();
        c_req = 1'b1; c_addr = 32'h504;
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h504}) begin
            fails++;
            $display("FAIL to_next_issue: req=%b addr=%h want 1 00000504", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({c_done, c_err, rdata} !== {2'b10, 32'h55}) begin
            fails++;
            $display("FAIL to_next_done: done=%b err=%b rdata=%h want 1 0 00000055", c_done, c_err, rdata);
        end
        c_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        c_req = 1'b1; c_addr = 32'h600;
        tick();
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rmid_busy: req=%b want 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({mem_req, c_done, d_done} !== 3'b000) begin
            fails++;
            $display("FAIL rmid_async: req=%b c=%b d=%b want 000", mem_req, c_done, d_done);
        end
        tick();
        tests++;
        if ({mem_req, c_done} !== 2'b00) begin
            fails++;
            $display("FAIL rmid_held: req=%b c=%b want 00", mem_req, c_done);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
            fails++;
            $display("FAIL rmid_regrant: req=%b addr=%h want 1 00000600", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h66;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({c_done, rdata} !== {1'b1, 32'h66}) begin
            fails++;
            $display("FAIL rmid_done: c=%b rdata=%h want 1 00000066", c_done, rdata);
        end
        c_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_arb_both();
        test_back_to_back();
        test_debug_write();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
